// File: rtl/toggle_gen.sv
// rtl/toggle_gen.sv - D/enable stimulus generator for exercising a D flip-flop with enable
//
// Two-state (IDLE/RUN) generator. A start with both periods nonzero latches
// the configuration and enters RUN. In RUN, o_d toggles every latched d
// period and o_enable every latched en period. A nonzero burst length ends
// the run on the edge producing that many o_d toggles.
//
// Parameters:
//   CNT_W         width of period, burst and toggle counters
//   CHK_W         width of the checker error counter
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_rst         synchronous active-high reset
//   i_start       start request (ignored while running)
//   i_stop        stop request (ignored while idle, wins over i_start)
//   i_d_period    cycles between o_d toggles
//   i_en_period   cycles between o_enable toggles
//   i_burst_len   o_d toggles per run, 0 = unlimited
//   o_d           generated data stimulus
//   o_enable      generated enable stimulus
//   o_busy        high while in RUN
//   o_cfg_err     one-cycle pulse on a start rejected for a zero period
//   o_toggle_cnt  o_d toggles in the current/last run, saturating
// Optional checker, built when TOGGLE_GEN_CHECK_EN is defined:
//   i_q           output of the flip-flop under test
//   o_mismatch    sticky mismatch flag, cleared by reset or accepted start
//   o_err_cnt     count of mismatching RUN cycles, saturating

module toggle_gen #(
   parameter int CNT_W = 16,
   parameter int CHK_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic [CNT_W-1:0] i_d_period,
   input  logic [CNT_W-1:0] i_en_period,
   input  logic [CNT_W-1:0] i_burst_len,
   output logic             o_d,
   output logic             o_enable,
   output logic             o_busy,
   output logic             o_cfg_err,
   output logic [CNT_W-1:0] o_toggle_cnt
`ifdef TOGGLE_GEN_CHECK_EN
   ,
   input  logic             i_q,
   output logic             o_mismatch,
   output logic [CHK_W-1:0] o_err_cnt
`endif
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   logic [CNT_W-1:0] d_per;
   logic [CNT_W-1:0] en_per;
   logic [CNT_W-1:0] burst;
   logic [CNT_W-1:0] d_ph;
   logic [CNT_W-1:0] en_ph;

   logic             start_ok;
   logic             d_hit;
   logic             en_hit;
   logic             burst_done;
   logic [CNT_W-1:0] cnt_next;

   assign start_ok = (state == S_IDLE) && i_start &&
                     (i_d_period != '0) && (i_en_period != '0);

   // Phase counters run 0..period-1; the toggle lands on the edge that
   // would take them to period, so period 1 toggles every cycle.
   assign d_hit  = (d_ph == d_per - CNT_ONE);
   assign en_hit = (en_ph == en_per - CNT_ONE);

   assign cnt_next   = (o_toggle_cnt == CNT_MAX) ? CNT_MAX : o_toggle_cnt + CNT_ONE;
   // The toggle about to happen is number burst when the count is burst-1.
   assign burst_done = (burst != '0) && (o_toggle_cnt == burst - CNT_ONE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_IDLE;
         o_d          <= 1'b0;
         o_enable     <= 1'b0;
         o_busy       <= 1'b0;
         o_cfg_err    <= 1'b0;
         o_toggle_cnt <= '0;
         d_per        <= '0;
         en_per       <= '0;
         burst        <= '0;
         d_ph         <= '0;
         en_ph        <= '0;
      end else begin
         o_cfg_err <= 1'b0;
         case (state)
            S_IDLE: begin
               // Also returns o_d/o_enable to 0 one cycle after a burst ends.
               o_d      <= 1'b0;
               o_enable <= 1'b0;
               if (start_ok) begin
                  d_per        <= i_d_period;
                  en_per       <= i_en_period;
                  burst        <= i_burst_len;
                  d_ph         <= '0;
                  en_ph        <= '0;
                  o_toggle_cnt <= '0;
                  o_busy       <= 1'b1;
                  state        <= S_RUN;
               end else if (i_start) begin
                  o_cfg_err <= 1'b1;
               end
            end
            S_RUN: begin
               if (i_stop) begin
                  o_d      <= 1'b0;
                  o_enable <= 1'b0;
                  o_busy   <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  if (d_hit) begin
                     d_ph         <= '0;
                     o_d          <= ~o_d;
                     o_toggle_cnt <= cnt_next;
                     if (burst_done) begin
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                     end
                  end else begin
                     d_ph <= d_ph + CNT_ONE;
                  end
                  if (en_hit) begin
                     en_ph    <= '0;
                     o_enable <= ~o_enable;
                  end else begin
                     en_ph <= en_ph + CNT_ONE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef TOGGLE_GEN_CHECK_EN
   localparam logic [CHK_W-1:0] CHK_ONE = {{(CHK_W-1){1'b0}}, 1'b1};
   localparam logic [CHK_W-1:0] CHK_MAX = {CHK_W{1'b1}};

   // Shadow of the flip-flop under test: same update rule it should follow.
   logic model_q;

   always_ff @(posedge i_clk) begin
      if (i_rst || start_ok) begin
         model_q    <= 1'b0;
         o_mismatch <= 1'b0;
         o_err_cnt  <= '0;
      end else begin
         if (o_enable) begin
            model_q <= o_d;
         end
         if ((state == S_RUN) && (i_q != model_q)) begin
            o_mismatch <= 1'b1;
            if (o_err_cnt != CHK_MAX) begin
               o_err_cnt <= o_err_cnt + CHK_ONE;
            end
         end
      end
   end
`endif

endmodule
